// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// The cache is 8 lines of 128 bits; a 28-bit block address is the tag followed by the index.
package icache_pkg;

    localparam int TAG_W   = 25;
    localparam int INDEX_W = 3;
    localparam int LINES   = 8;
    localparam int LINE_W  = 128;
    localparam int BLOCK_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_READ,
        S_UPDATE
    } state_t;

    // Pick 32-bit word 'sel' out of a line; word 0 is bytes 3..0.
    function automatic logic [31:0] select_word(input logic [LINE_W-1:0] line,
                                                input logic [1:0]        sel);
        return line[32*sel +: 32];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Data, tag and valid storage: asynchronous read, synchronous write,
// and valid bits cleared by the asynchronous reset (data and tags are never reset).
module icache_line_array
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [LINE_W-1:0]  rd_line,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line
);

    logic [LINE_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_index] <= wr_line;
            tag_mem[wr_index]  <= wr_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_index] <= 1'b1;
        end
    end

    assign rd_line  = data_mem[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_reg[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with zero-latency hits and a three-state refill FSM.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module instruction_cache
    import icache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [31:0]         PC_ADDRESS,
    output logic [31:0]         INSTRUCTION,
    output logic                CPU_BUSYWAIT,
    output logic                MEM_READ,
    output logic [BLOCK_W-1:0]  MEM_ADDRESS,
    input  logic [LINE_W-1:0]   MEM_READDATA,
    input  logic                MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]         HIT_COUNT,
    output logic [15:0]         MISS_COUNT
`endif
);

    state_t state_reg, state_next;
    logic [BLOCK_W-1:0] miss_reg;

    logic [TAG_W-1:0]   pc_tag;
    logic [INDEX_W-1:0] pc_index;
    logic [1:0]         pc_word;
    logic               pc_unused;

    logic [LINE_W-1:0]  rd_line;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               hit;

    logic               busy_next;
    logic               fill_en;
    logic               hit_idle;
    logic [31:0]        instr_next;
    logic               mem_read_next;
    logic [BLOCK_W-1:0] mem_addr_next;

    assign pc_tag    = PC_ADDRESS[31:7];
    assign pc_index  = PC_ADDRESS[6:4];
    assign pc_word   = PC_ADDRESS[3:2];
    assign pc_unused = &{1'b0, PC_ADDRESS[1:0]};

    icache_line_array u_lines (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .rd_index (pc_index),
        .rd_line  (rd_line),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (fill_en),
        .wr_index (miss_reg[INDEX_W-1:0]),
        .wr_tag   (miss_reg[BLOCK_W-1:INDEX_W]),
        .wr_line  (MEM_READDATA)
    );

    assign hit = rd_valid && (rd_tag == pc_tag);

    always_comb begin
        state_next    = state_reg;
        busy_next     = 1'b0;
        fill_en       = 1'b0;
        hit_idle      = 1'b0;
        instr_next    = 32'h0;
        mem_read_next = 1'b0;
        mem_addr_next = '0;
        case (state_reg)
            S_IDLE: begin
                if (hit) begin
                    hit_idle   = 1'b1;
                    instr_next = select_word(rd_line, pc_word);
                end else begin
                    busy_next  = 1'b1;
                    state_next = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                busy_next     = 1'b1;
                mem_read_next = 1'b1;
                mem_addr_next = miss_reg;
                if (!MEM_BUSYWAIT) begin
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy_next  = 1'b1;
                fill_en    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Valid bits are all clear during reset, so the IDLE miss path would otherwise stall the CPU.
    assign CPU_BUSYWAIT = busy_next && RESET_N;
    assign INSTRUCTION  = instr_next;
    assign MEM_READ     = mem_read_next;
    assign MEM_ADDRESS  = mem_addr_next;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= S_IDLE;
            miss_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && !hit) begin
                miss_reg <= {pc_tag, pc_index};
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_reg;
    logic [15:0] miss_count_reg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_idle && hit_count_reg != 16'hFFFF) begin
                hit_count_reg <= hit_count_reg + 16'd1;
            end
            if (state_reg == S_IDLE && state_next == S_MEM_READ && miss_count_reg != 16'hFFFF) begin
                miss_count_reg <= miss_count_reg + 16'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_count_reg;
    assign MISS_COUNT = miss_count_reg;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed testbench for instruction_cache with a behavioural instruction memory
// whose busy time is set per access; checks counters too when ICACHE_STATS_EN is defined.
module tb_instruction_cache;

    logic         CLK;
    logic         RESET_N;
    logic [31:0]  PC_ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         CPU_BUSYWAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [15:0]  HIT_COUNT;
    logic [15:0]  MISS_COUNT;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_hits   = 0;
    int exp_misses = 0;
    int mem_busy_cycles = 0;
    int busy_cnt = 0;
    logic [127:0] data_reg;

    instruction_cache dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .PC_ADDRESS   (PC_ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .CPU_BUSYWAIT (CPU_BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_of(input logic [27:0] block, input logic [1:0] w);
        return {8'hA5, block[21:0], w};
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] block);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) begin
            l[32*w +: 32] = word_of(block, 2'(w));
        end
        return l;
    endfunction

    // Memory: busy for mem_busy_cycles read cycles, delivers the line on the edge it goes idle,
    // and holds junk at every other time so a fill from the wrong cycle is visible.
    assign MEM_BUSYWAIT = MEM_READ && (busy_cnt < mem_busy_cycles);
    assign MEM_READDATA = data_reg;

    always @(posedge CLK) begin
        if (MEM_READ) begin
            busy_cnt <= busy_cnt + 1;
            if (!MEM_BUSYWAIT) data_reg <= line_of(MEM_ADDRESS);
            else               data_reg <= {4{32'hDEAD_BEEF}};
        end else begin
            busy_cnt <= 0;
            data_reg <= {4{32'hBAD0_BAD0}};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_stats();
`ifdef ICACHE_STATS_EN
        check("hit_count", HIT_COUNT, 64'(exp_hits));
        check("miss_count", MISS_COUNT, 64'(exp_misses));
`endif
    endtask

    // One access: present pc right after an edge, follow any miss to completion, then take one hit edge.
    task automatic access(input logic [31:0] pc, input logic exp_miss, input int busy);
        int stall = 0;
        int mr = 0;
        PC_ADDRESS = pc;
        mem_busy_cycles = busy;
        @(negedge CLK);
        check("cpu_busywait", CPU_BUSYWAIT, exp_miss);
        if (CPU_BUSYWAIT) begin
            while (CPU_BUSYWAIT && stall < 40) begin
                if (MEM_READ) begin
                    mr++;
                    check("mem_address", MEM_ADDRESS, pc[31:4]);
                end else begin
                    check("mem_address_idle", MEM_ADDRESS, 0);
                end
                stall++;
                @(negedge CLK);
            end
            check("stall_cycles", stall, 3 + busy);
            check("mem_read_cycles", mr, busy + 1);
            exp_misses++;
        end else begin
            check("mem_read_on_hit", MEM_READ, 0);
        end
        check("instruction", INSTRUCTION, word_of(pc[31:4], pc[3:2]));
        exp_hits++;
        $display("access pc=%08h stall=%0d instr=%08h", pc, stall, INSTRUCTION);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall;
        RESET_N    = 1'b0;
        PC_ADDRESS = 32'h0;
        repeat (2) @(negedge CLK);
        check("reset_busywait", CPU_BUSYWAIT, 0);
        check("reset_instruction", INSTRUCTION, 0);
        check("reset_mem_read", MEM_READ, 0);
        check("reset_mem_address", MEM_ADDRESS, 0);
        check_stats();
        @(posedge CLK);
        #1 RESET_N = 1'b1;

        access(32'h0000_0000, 1'b1, 0);
        check_stats();
        access(32'h0000_0004, 1'b0, 0);
        access(32'h0000_0008, 1'b0, 0);
        access(32'h0000_000C, 1'b0, 0);
        check_stats();

        access(32'h0000_0080, 1'b1, 0);
        access(32'h0000_0000, 1'b1, 0);
        check_stats();

        access(32'h0000_0040, 1'b1, 5);
        access(32'h0000_0044, 1'b0, 0);

        // PC moves from 0x10 to 0x20 while the miss for 0x10 is in flight.
        PC_ADDRESS = 32'h0000_0010;
        mem_busy_cycles = 0;
        @(negedge CLK);
        check("redirect_miss", CPU_BUSYWAIT, 1);
        @(posedge CLK);
        #1 PC_ADDRESS = 32'h0000_0020;
        @(negedge CLK);
        check("redirect_mem_read", MEM_READ, 1);
        check("redirect_mem_address", MEM_ADDRESS, 28'h1);
        @(negedge CLK);
        check("redirect_update_read", MEM_READ, 0);
        check("redirect_update_busy", CPU_BUSYWAIT, 1);
        @(negedge CLK);
        check("redirect_second_miss", CPU_BUSYWAIT, 1);
        stall = 0;
        while (CPU_BUSYWAIT && stall < 40) begin
            stall++;
            @(negedge CLK);
        end
        check("redirect_stall", stall, 3);
        check("redirect_instruction", INSTRUCTION, word_of(28'h2, 2'd0));
        exp_misses += 2;
        exp_hits++;
        $display("access pc=00000010->00000020 stall=%0d instr=%08h", stall, INSTRUCTION);
        @(posedge CLK);
        #1;
        access(32'h0000_0010, 1'b0, 0);
        check_stats();

        // Reset in the middle of a refill.
        PC_ADDRESS = 32'h0000_0030;
        mem_busy_cycles = 5;
        @(negedge CLK);
        @(negedge CLK);
        check("midmiss_mem_read", MEM_READ, 1);
        #1 RESET_N = 1'b0;
        #1;
        check("midmiss_reset_mem_read", MEM_READ, 0);
        check("midmiss_reset_mem_address", MEM_ADDRESS, 0);
        check("midmiss_reset_busywait", CPU_BUSYWAIT, 0);
        check("midmiss_reset_instruction", INSTRUCTION, 0);
        $display("reset asserted during refill of pc=00000030");
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        mem_busy_cycles = 0;
        exp_hits = 0;
        exp_misses = 0;
        check_stats();
        access(32'h0000_0000, 1'b1, 0);
        access(32'h0000_0030, 1'b1, 0);
        check_stats();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
